// File: rtl/fetch_buffer_pkg.sv
// rtl/fetch_buffer_pkg.sv - shared widths and control states for the fetch buffer
`timescale 1ns/1ps
package fetch_buffer_pkg;

    localparam int FB_DATA_WIDTH = 32;
    localparam int FB_DEPTH      = 4;

    typedef enum logic [1:0] {
        FB_IDLE = 2'd0,
        FB_WAIT = 2'd1,
        FB_DROP = 2'd2
    } fb_state_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// rtl/fetch_buffer_if.sv - PC, instruction memory and decode-side signals of the fetch buffer
`timescale 1ns/1ps
interface fetch_buffer_if
    import fetch_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = FB_DATA_WIDTH
) ();

    logic                  pc_stall;
    logic [DATA_WIDTH-1:0] pc;
    logic                  redirect;
    logic                  imem_req;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic                  imem_ack;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  inst_valid;
    logic [DATA_WIDTH-1:0] inst;
    logic [DATA_WIDTH-1:0] inst_pc;
    logic                  inst_ready;

    modport master (
        input  pc, redirect, imem_ack, imem_rdata, inst_ready,
        output pc_stall, imem_req, imem_addr, inst_valid, inst, inst_pc
    );

    modport slave (
        output pc, redirect, imem_ack, imem_rdata, inst_ready,
        input  pc_stall, imem_req, imem_addr, inst_valid, inst, inst_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - {pc, instruction} queue between instruction memory and decode
`timescale 1ns/1ps
module fetch_fifo
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH      = FB_DEPTH,
    parameter int DATA_WIDTH = FB_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic                  i_flush,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic [DATA_WIDTH-1:0] i_inst,
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic [DATA_WIDTH-1:0] o_inst,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [2*DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [AW:0]             r_count;
    logic                    w_push;
    logic                    w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_pc    = r_mem[r_rd_ptr][2*DATA_WIDTH-1:DATA_WIDTH];
    assign o_inst  = r_mem[r_rd_ptr][DATA_WIDTH-1:0];

    // Flush wins over any same-cycle push or pop so no wrong-path word survives a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {i_pc, i_inst};
    end

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - single-outstanding instruction fetch with redirect flush and PC hold
`timescale 1ns/1ps
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = FB_DATA_WIDTH,
    parameter int DEPTH      = FB_DEPTH
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_buffer_if.master bus
);

    fb_state_t             r_state;
    fb_state_t             w_next;
    logic                  r_req;
    logic [DATA_WIDTH-1:0] r_addr;
    logic                  w_issue;
    logic                  w_done;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [DATA_WIDTH-1:0] w_head_pc;
    logic [DATA_WIDTH-1:0] w_head_inst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FB_IDLE;
        else        r_state <= w_next;
    end

    // A redirect while waiting turns the outstanding read into one whose word is thrown away.
    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        w_done  = 1'b0;
        w_push  = 1'b0;
        case (r_state)
            FB_IDLE: begin
                if (!w_full && !bus.redirect) begin
                    w_issue = 1'b1;
                    w_next  = FB_WAIT;
                end
            end
            FB_WAIT: begin
                if (bus.imem_ack) begin
                    w_done = 1'b1;
                    w_push = !bus.redirect;
                    w_next = FB_IDLE;
                end else if (bus.redirect) begin
                    w_next = FB_DROP;
                end
            end
            FB_DROP: begin
                if (bus.imem_ack) begin
                    w_done = 1'b1;
                    w_next = FB_IDLE;
                end
            end
            default: w_next = FB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req  <= 1'b0;
            r_addr <= '0;
        end else if (w_issue) begin
            r_req  <= 1'b1;
            r_addr <= bus.pc;
        end else if (w_done) begin
            r_req  <= 1'b0;
        end
    end

    assign w_pop = !w_empty && bus.inst_ready;

    fetch_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redirect),
        .i_pc    (r_addr),
        .i_inst  (bus.imem_rdata),
        .o_pc    (w_head_pc),
        .o_inst  (w_head_inst),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // PC moves only when its word is captured, and a redirect is always let through.
    assign bus.pc_stall   = !(bus.redirect || (r_state == FB_WAIT && bus.imem_ack));
    assign bus.imem_req   = r_req;
    assign bus.imem_addr  = r_addr;
    assign bus.inst_valid = !w_empty;
    assign bus.inst       = w_head_inst;
    assign bus.inst_pc    = w_head_pc;

endmodule
